uart_pkt_ctrl: RTL and testbench

UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

---
 rtl/uart_pkt_if.sv | 23 ++
 rtl/uart_pkt_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_if.sv
// Byte stream in from a UART receiver, register-write strobes and packet status out.
// Handshake: rx_valid and wr_en are single-cycle strobes with no back-pressure; data is valid only while the strobe is high.
interface uart_pkt_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       pkt_ok;
   logic       pkt_err;
   logic [1:0] err_code;

   modport master (
      output rx_data, rx_valid,
      input  wr_en, wr_addr, wr_data, busy, pkt_ok, pkt_err, err_code
   );

   modport slave (
      input  rx_data, rx_valid,
      output wr_en, wr_addr, wr_data, busy, pkt_ok, pkt_err, err_code
   );
endinterface

// File: rtl/uart_pkt_ctrl.sv
// Parses SYNC/ADDR/LEN/payload/CSUM packets from a UART byte stream and replays
// the payload as consecutive register writes once the XOR checksum matches.
module uart_pkt_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         MAX_LEN   = 8,
   parameter int         TIMEOUT   = 104160
) (
   input  logic       clk,
   input  logic       rst,
   uart_pkt_if.slave  bus,
   output logic [2:0] dbg_state
);

   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_SYNC    = 3'd0,
      S_ADDR    = 3'd1,
      S_LEN     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_CSUM    = 3'd4,
      S_COMMIT  = 3'd5
   } state_t;

   state_t        state, state_n;
   logic [7:0]    addr_q, addr_n;
   logic [7:0]    acc_q, acc_n;
   logic [IW-1:0] len_q, len_n;
   logic [IW-1:0] idx_q, idx_n;
   logic [TW-1:0] tmo_q, tmo_n;
   logic [7:0]    pl_buf [2**AW];
   logic          buf_we;
   logic          tmo_hit;
   logic          wr_en_n, pkt_ok_n, pkt_err_n;
   logic [7:0]    wr_addr_n, wr_data_n;
   logic [1:0]    err_n;

   assign dbg_state = state;
   assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1)) && !bus.rx_valid;

   always_comb begin
      state_n   = state;
      addr_n    = addr_q;
      acc_n     = acc_q;
      len_n     = len_q;
      idx_n     = idx_q;
      buf_we    = 1'b0;
      wr_en_n   = 1'b0;
      wr_addr_n = bus.wr_addr;
      wr_data_n = bus.wr_data;
      pkt_ok_n  = 1'b0;
      pkt_err_n = 1'b0;
      err_n     = bus.err_code;

      case (state)
         S_SYNC: begin
            if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_n = S_ADDR;
         end
         S_ADDR: begin
            if (bus.rx_valid) begin
               addr_n  = bus.rx_data;
               acc_n   = bus.rx_data;
               state_n = S_LEN;
            end else if (tmo_hit) begin
               pkt_err_n = 1'b1;
               err_n     = 2'd3;
               state_n   = S_SYNC;
            end
         end
         S_LEN: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == 8'd0 || bus.rx_data > 8'(MAX_LEN)) begin
                  pkt_err_n = 1'b1;
                  err_n     = 2'd1;
                  state_n   = S_SYNC;
               end else begin
                  len_n   = bus.rx_data[IW-1:0];
                  acc_n   = acc_q ^ bus.rx_data;
                  idx_n   = '0;
                  state_n = S_PAYLOAD;
               end
            end else if (tmo_hit) begin
               pkt_err_n = 1'b1;
               err_n     = 2'd3;
               state_n   = S_SYNC;
            end
         end
         S_PAYLOAD: begin
            if (bus.rx_valid) begin
               buf_we = 1'b1;
               acc_n  = acc_q ^ bus.rx_data;
               idx_n  = idx_q + IW'(1);
               if (idx_n == len_q) state_n = S_CSUM;
            end else if (tmo_hit) begin
               pkt_err_n = 1'b1;
               err_n     = 2'd3;
               state_n   = S_SYNC;
            end
         end
         S_CSUM: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == acc_q) begin
                  // First write leaves with the CSUM byte, so idx starts at 1 inside S_COMMIT.
                  wr_en_n   = 1'b1;
                  wr_addr_n = addr_q;
                  wr_data_n = pl_buf[0];
                  idx_n     = IW'(1);
                  state_n   = S_COMMIT;
               end else begin
                  pkt_err_n = 1'b1;
                  err_n     = 2'd2;
                  state_n   = S_SYNC;
               end
            end else if (tmo_hit) begin
               pkt_err_n = 1'b1;
               err_n     = 2'd3;
               state_n   = S_SYNC;
            end
         end
         S_COMMIT: begin
            if (idx_q == len_q) begin
               pkt_ok_n = 1'b1;
               err_n    = 2'd0;
               idx_n    = '0;
               state_n  = S_SYNC;
            end else begin
               wr_en_n   = 1'b1;
               wr_addr_n = addr_q + 8'(idx_q);
               wr_data_n = pl_buf[idx_q[AW-1:0]];
               idx_n     = idx_q + IW'(1);
            end
         end
         default: state_n = S_SYNC;
      endcase

      if (state_n != state || bus.rx_valid || state == S_SYNC || state == S_COMMIT)
         tmo_n = '0;
      else
         tmo_n = tmo_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_SYNC;
         addr_q       <= '0;
         acc_q        <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         tmo_q        <= '0;
         bus.wr_en    <= 1'b0;
         bus.wr_addr  <= '0;
         bus.wr_data  <= '0;
         bus.busy     <= 1'b0;
         bus.pkt_ok   <= 1'b0;
         bus.pkt_err  <= 1'b0;
         bus.err_code <= 2'd0;
      end else begin
         state        <= state_n;
         addr_q       <= addr_n;
         acc_q        <= acc_n;
         len_q        <= len_n;
         idx_q        <= idx_n;
         tmo_q        <= tmo_n;
         bus.wr_en    <= wr_en_n;
         bus.wr_addr  <= wr_addr_n;
         bus.wr_data  <= wr_data_n;
         bus.busy     <= (state_n == S_COMMIT);
         bus.pkt_ok   <= pkt_ok_n;
         bus.pkt_err  <= pkt_err_n;
         bus.err_code <= err_n;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) pl_buf[idx_q[AW-1:0]] <= bus.rx_data;
   end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Packet-level bench for uart_pkt_ctrl: vector table of whole packets, write
// scoreboard, and hand-written timeout / reset-in-commit sequences.
module tb_uart_pkt_ctrl;
   localparam int MAX_LEN = 8;
   localparam int TIMEOUT = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] dbg_state;

   uart_pkt_if bus ();

   uart_pkt_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] len;
      int         npl;
      logic [7:0] pl [8];
      bit         send_csum;
      bit         bad_csum;
      logic [7:0] csum_ovr;
      int         exp_wr;
      bit         exp_ok;
      bit         exp_err;
      logic [1:0] exp_code;
   } vec_t;

   vec_t vecs[$];
   logic [15:0] exp_q[$];

   int checks = 0;
   int errors = 0;
   int neg_cyc = 0;
   int wr_cnt = 0, ok_cnt = 0, err_cnt = 0;
   int err_cyc = 0, first_wr_cyc = 0;
   bit first_pending = 0;
   bit prev_wr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      neg_cyc++;
      if (!rst) begin
         if (bus.wr_en || bus.pkt_ok || bus.pkt_err)
            check("excl", int'(bus.wr_en) + int'(bus.pkt_ok) + int'(bus.pkt_err), 1);
         if (bus.wr_en || bus.busy) check("busy", bus.busy, bus.wr_en);
         if (bus.wr_en) begin
            wr_cnt++;
            if (first_pending) begin
               first_wr_cyc  = neg_cyc;
               first_pending = 0;
            end else begin
               check("wr_gap", prev_wr, 1);
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexp: got %h:%h expected no write", bus.wr_addr, bus.wr_data);
            end else begin
               check("wr", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
            end
         end
         if (bus.pkt_ok) begin
            ok_cnt++;
            check("ok_after_wr", prev_wr, 1);
            check("ok_code", bus.err_code, 0);
         end
         if (bus.pkt_err) begin
            err_cnt++;
            err_cyc = neg_cyc;
         end
      end
      prev_wr = bus.wr_en;
   end

   task automatic add_vec(input logic [7:0] addr, input logic [7:0] len, input int npl,
                          input logic [63:0] plbits, input bit send_csum, input bit bad_csum,
                          input logic [7:0] csum_ovr, input int exp_wr, input bit exp_ok,
                          input bit exp_err, input logic [1:0] exp_code);
      vec_t v;
      v.addr = addr; v.len = len; v.npl = npl;
      for (int i = 0; i < 8; i++) v.pl[i] = plbits[8*i +: 8];
      v.send_csum = send_csum; v.bad_csum = bad_csum; v.csum_ovr = csum_ovr;
      v.exp_wr = exp_wr; v.exp_ok = exp_ok; v.exp_err = exp_err; v.exp_code = exp_code;
      vecs.push_back(v);
   endtask

   // Called at the start of a cycle (just after a rising edge); returns likewise.
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int wr0, ok0, err0, n, ng;
      logic [7:0] c, g;
      wr0 = wr_cnt; ok0 = ok_cnt; err0 = err_cnt; n = 0;
      ng = $urandom_range(0, 3);
      for (int i = 0; i < ng; i++) begin
         g = 8'($urandom_range(0, 255));
         if (g == 8'hA5) g = 8'h5A;
         send_byte(g, $urandom_range(0, 2));
      end
      send_byte(8'hA5, $urandom_range(0, 2));
      send_byte(v.addr, $urandom_range(0, 2));
      send_byte(v.len, $urandom_range(0, 2));
      c = v.addr ^ v.len;
      for (int i = 0; i < v.npl; i++) begin
         c ^= v.pl[i];
         send_byte(v.pl[i], $urandom_range(0, 2));
      end
      if (v.send_csum) begin
         if (v.bad_csum) c = v.csum_ovr;
         if (v.exp_ok) begin
            for (int i = 0; i < v.npl; i++) exp_q.push_back({v.addr + 8'(i), v.pl[i]});
            first_pending = 1;
         end
         send_byte(c, $urandom_range(0, 2));
         n = neg_cyc;
      end
      repeat (MAX_LEN + 6) @(posedge clk);
      #1;
      check($sformatf("v%0d_wr", k), wr_cnt - wr0, v.exp_wr);
      check($sformatf("v%0d_ok", k), ok_cnt - ok0, int'(v.exp_ok));
      check($sformatf("v%0d_err", k), err_cnt - err0, int'(v.exp_err));
      check($sformatf("v%0d_code", k), bus.err_code, v.exp_code);
      check($sformatf("v%0d_q", k), exp_q.size(), 0);
      check($sformatf("v%0d_state", k), dbg_state, 0);
      if (v.exp_ok) check($sformatf("v%0d_lat", k), first_wr_cyc, n + 1);
      exp_q.delete();
      first_pending = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int wr0, ok0, err0, n;
      bit hit;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_pkt_ok", bus.pkt_ok, 0);
      check("rst_pkt_err", bus.pkt_err, 0);
      check("rst_err_code", bus.err_code, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      //       addr   len    npl payload (byte0 in LSB)   csum bad  ovr    wr ok err code
      add_vec(8'h10, 8'h03, 3, 64'h0000_0000_0033_2211, 1, 0, 8'h00, 3, 1, 0, 2'd0);
      add_vec(8'hFE, 8'h03, 3, 64'h0000_0000_0003_0201, 1, 0, 8'h00, 3, 1, 0, 2'd0);
      add_vec(8'h10, 8'h02, 2, 64'h0000_0000_0000_BBAA, 1, 1, 8'h00, 0, 0, 1, 2'd2);
      add_vec(8'h10, 8'h09, 0, 64'h0,                   0, 0, 8'h00, 0, 0, 1, 2'd1);
      add_vec(8'h50, 8'h02, 2, 64'h0000_0000_0000_C35A, 1, 0, 8'h00, 2, 1, 0, 2'd0);
      add_vec(8'h20, 8'h00, 0, 64'h0,                   0, 0, 8'h00, 0, 0, 1, 2'd1);
      add_vec(8'h30, 8'h08, 8, 64'h0706_0504_0302_01A5, 1, 0, 8'h00, 8, 1, 0, 2'd0);
      add_vec(8'h40, 8'h01, 1, 64'h0000_0000_0000_00A5, 1, 0, 8'h00, 1, 1, 0, 2'd0);
      for (int k = 0; k < vecs.size(); k++) run_vec(k, vecs[k]);

      // Silence after ADDR: error fires TIMEOUT cycles after the last byte.
      err0 = err_cnt; wr0 = wr_cnt;
      send_byte(8'hA5, 0);
      send_byte(8'h10, 0);
      n = neg_cyc;
      repeat (TIMEOUT + 5) @(posedge clk);
      #1;
      check("tmo_err", err_cnt - err0, 1);
      check("tmo_code", bus.err_code, 3);
      check("tmo_cycle", err_cyc, n + TIMEOUT + 1);
      check("tmo_state", dbg_state, 0);
      check("tmo_wr", wr_cnt - wr0, 0);

      // A byte landing exactly on the timeout cycle is accepted.
      err0 = err_cnt; ok0 = ok_cnt; wr0 = wr_cnt;
      send_byte(8'hA5, 0);
      send_byte(8'h60, TIMEOUT - 1);
      send_byte(8'h02, TIMEOUT - 1);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      exp_q.push_back({8'h60, 8'h01});
      exp_q.push_back({8'h61, 8'h02});
      first_pending = 1;
      send_byte(8'h60 ^ 8'h02 ^ 8'h01 ^ 8'h02, TIMEOUT - 1);
      repeat (MAX_LEN + 6) @(posedge clk);
      #1;
      check("edge_err", err_cnt - err0, 0);
      check("edge_ok", ok_cnt - ok0, 1);
      check("edge_wr", wr_cnt - wr0, 2);
      check("edge_code", bus.err_code, 0);
      first_pending = 0;
      exp_q.delete();

      // Reset after the second write of an 8-byte packet aborts the rest.
      ok0 = ok_cnt; wr0 = wr_cnt;
      send_byte(8'hA5, 0);
      send_byte(8'h80, 0);
      send_byte(8'h08, 0);
      for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), 0);
      exp_q.push_back({8'h80, 8'hC0});
      exp_q.push_back({8'h81, 8'hC1});
      first_pending = 1;
      send_byte(8'h80 ^ 8'h08 ^ 8'hC0 ^ 8'hC1 ^ 8'hC2 ^ 8'hC3 ^ 8'hC4 ^ 8'hC5 ^ 8'hC6 ^ 8'hC7, 0);
      hit = 0;
      for (int t = 0; t < 40 && !hit; t++) begin
         @(negedge clk);
         #1;
         if (wr_cnt - wr0 >= 2) hit = 1;
      end
      check("rc_reach_2nd_wr", hit, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rc_wr_en", bus.wr_en, 0);
      check("rc_wr_addr", bus.wr_addr, 0);
      check("rc_wr_data", bus.wr_data, 0);
      check("rc_busy", bus.busy, 0);
      check("rc_pkt_ok", bus.pkt_ok, 0);
      check("rc_pkt_err", bus.pkt_err, 0);
      check("rc_err_code", bus.err_code, 0);
      check("rc_state", dbg_state, 0);
      rst = 1'b0;
      repeat (MAX_LEN + 6) @(posedge clk);
      #1;
      check("rc_wr", wr_cnt - wr0, 2);
      check("rc_ok", ok_cnt - ok0, 0);
      check("rc_q", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
